// File: rtl/count_tracker_if.sv
// Bus between the up/down counter tap and the count_tracker checker.
interface count_tracker_if #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned WRAP_CNT_W = 8
);
  logic                  en;
  logic                  clr;
  logic [WIDTH-1:0]      cnt_in;
  logic                  mode;
  logic                  wrap_pulse;
  logic                  wrap_dir;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic                  err_pulse;
  logic                  step_err;
  logic                  fault;

  // Upstream side: presents samples, observes status.
  modport master (
    output en, clr, cnt_in, mode,
    input  wrap_pulse, wrap_dir, wrap_count, err_pulse, step_err, fault
  );

  // Checker side.
  modport slave (
    input  en, clr, cnt_in, mode,
    output wrap_pulse, wrap_dir, wrap_count, err_pulse, step_err, fault
  );
endinterface

// File: rtl/count_tracker.sv
// Step checker and wrap statistics for a WIDTH-bit up/down counter.
module count_tracker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned WRAP_CNT_W = 8
) (
  input  logic           clk,
  input  logic           rstn,
  count_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_prev;
  logic                  r_mode_q;
  logic                  r_wrap_pulse;
  logic                  r_wrap_dir;
  logic [WRAP_CNT_W-1:0] r_wrap_count;
  logic                  r_err_pulse;
  logic                  r_step_err;
  logic                  r_fault;

  state_t                w_state_nxt;
  logic [WIDTH-1:0]      w_prev_nxt;
  logic                  w_mode_nxt;
  logic                  w_wrap_pulse_nxt;
  logic                  w_wrap_dir_nxt;
  logic [WRAP_CNT_W-1:0] w_wrap_count_nxt;
  logic                  w_err_pulse_nxt;
  logic                  w_step_err_nxt;
  logic                  w_fault_nxt;
  logic [WIDTH-1:0]      w_exp;
  logic                  w_at_wrap;

  // Value the counter must show now, given the last sample and its direction.
  assign w_exp     = r_mode_q ? (r_prev + WIDTH'(1)) : (r_prev - WIDTH'(1));
  // A legal step from this prev in this direction crosses the modulo boundary.
  assign w_at_wrap = r_mode_q ? (r_prev == '1) : (r_prev == '0);

  // Next-state and next-output logic; clr outranks any sample in the same cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_mode_nxt       = r_mode_q;
    w_wrap_pulse_nxt = 1'b0;
    w_wrap_dir_nxt   = r_wrap_dir;
    w_wrap_count_nxt = r_wrap_count;
    w_err_pulse_nxt  = 1'b0;
    w_step_err_nxt   = r_step_err;

    if (bus.clr) begin
      w_state_nxt      = ST_INIT;
      w_prev_nxt       = '0;
      w_mode_nxt       = 1'b0;
      w_wrap_dir_nxt   = 1'b0;
      w_wrap_count_nxt = '0;
      w_step_err_nxt   = 1'b0;
    end else if (bus.en) begin
      w_prev_nxt = bus.cnt_in;
      w_mode_nxt = bus.mode;
      case (r_state)
        ST_INIT: w_state_nxt = ST_TRACK;
        ST_TRACK: begin
          if (bus.cnt_in == w_exp) begin
            if (w_at_wrap) begin
              w_wrap_pulse_nxt = 1'b1;
              w_wrap_dir_nxt   = r_mode_q;
              if (r_wrap_count != '1) begin
                w_wrap_count_nxt = r_wrap_count + WRAP_CNT_W'(1);
              end
            end
          end else begin
            w_err_pulse_nxt = 1'b1;
            w_step_err_nxt  = 1'b1;
            w_state_nxt     = ST_FAULT;
          end
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_INIT;
      endcase
    end

    w_fault_nxt = (w_state_nxt == ST_FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_INIT;
      r_prev       <= '0;
      r_mode_q     <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_wrap_dir   <= 1'b0;
      r_wrap_count <= '0;
      r_err_pulse  <= 1'b0;
      r_step_err   <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_mode_q     <= w_mode_nxt;
      r_wrap_pulse <= w_wrap_pulse_nxt;
      r_wrap_dir   <= w_wrap_dir_nxt;
      r_wrap_count <= w_wrap_count_nxt;
      r_err_pulse  <= w_err_pulse_nxt;
      r_step_err   <= w_step_err_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

  assign bus.wrap_pulse = r_wrap_pulse;
  assign bus.wrap_dir   = r_wrap_dir;
  assign bus.wrap_count = r_wrap_count;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.step_err   = r_step_err;
  assign bus.fault      = r_fault;

endmodule

// File: tb/tb_count_tracker.sv
// Scoreboard bench for count_tracker: two instances (8-bit and 2-bit wrap counters)
// share one stimulus stream and are checked against a behavioural model.
module tb_count_tracker;

  localparam int unsigned WIDTH = 4;
  localparam int M_INIT  = 0;
  localparam int M_TRACK = 1;
  localparam int M_FAULT = 2;

  logic clk;
  logic rstn;

  count_tracker_if #(.WIDTH(WIDTH), .WRAP_CNT_W(8)) ifa ();
  count_tracker_if #(.WIDTH(WIDTH), .WRAP_CNT_W(2)) ifb ();

  count_tracker #(.WIDTH(WIDTH), .WRAP_CNT_W(8)) u_dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
  count_tracker #(.WIDTH(WIDTH), .WRAP_CNT_W(2)) u_dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit wp;
    bit wd;
    int wca;
    int wcb;
    bit ep;
    bit se;
    bit flt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   hold_rst = 1'b0;

  // Behavioural model state
  int m_st, m_prev, m_wca, m_wcb;
  bit m_mq, m_wd, m_se;
  exp_t cur;

  function automatic void model_reset();
    m_st = M_INIT; m_prev = 0; m_mq = 0; m_wca = 0; m_wcb = 0; m_wd = 0; m_se = 0;
    cur.wp = 0; cur.ep = 0;
  endfunction

  function automatic void model_fill();
    cur.wd = m_wd; cur.wca = m_wca; cur.wcb = m_wcb; cur.se = m_se;
    cur.flt = (m_st == M_FAULT);
  endfunction

  function automatic void model_step(input bit e, input bit c, input int v, input bit m);
    int nxt;
    cur.wp = 0;
    cur.ep = 0;
    if (!rstn || c) begin
      model_reset();
    end else if (e) begin
      if (m_st == M_TRACK) begin
        nxt = (m_prev + (m_mq ? 1 : 15)) % 16;
        if (v == nxt) begin
          if ((m_mq && m_prev == 15) || (!m_mq && m_prev == 0)) begin
            cur.wp = 1;
            m_wd = m_mq;
            if (m_wca < 255) m_wca++;
            if (m_wcb < 3) m_wcb++;
          end
        end else begin
          cur.ep = 1;
          m_se = 1;
          m_st = M_FAULT;
        end
      end else if (m_st == M_INIT) begin
        m_st = M_TRACK;
      end
      m_prev = v;
      m_mq = m;
    end
    model_fill();
  endfunction

  function automatic void check_one(input string nm, input logic wp, input logic wd, input int wc,
                                    input logic wcx, input logic ep, input logic se, input logic fl,
                                    input bit xwp, input bit xwd, input int xwc, input bit xep,
                                    input bit xse, input bit xfl);
    n_vec++;
    if (wp !== xwp || wd !== xwd || wc != xwc || wcx !== 1'b0 || ep !== xep || se !== xse || fl !== xfl) begin
      n_err++;
      $display("FAIL %s t=%0t got wp=%b wd=%b wc=%0d ep=%b se=%b flt=%b want wp=%b wd=%b wc=%0d ep=%b se=%b flt=%b",
               nm, $time, wp, wd, wc, ep, se, fl, xwp, xwd, xwc, xep, xse, xfl);
    end
  endfunction

  function automatic void check_both(input string tag, input exp_t x);
    check_one({tag, "_A"}, ifa.wrap_pulse, ifa.wrap_dir, int'(ifa.wrap_count), ^ifa.wrap_count === 1'bx,
              ifa.err_pulse, ifa.step_err, ifa.fault, x.wp, x.wd, x.wca, x.ep, x.se, x.flt);
    check_one({tag, "_B"}, ifb.wrap_pulse, ifb.wrap_dir, int'(ifb.wrap_count), ^ifb.wrap_count === 1'bx,
              ifb.err_pulse, ifb.step_err, ifb.fault, x.wp, x.wd, x.wcb, x.ep, x.se, x.flt);
  endfunction

  // Monitor: after every rising edge, compare both DUTs with the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check_both("cycle", x);
      end
    end
  end

  task automatic drive(input bit e, input bit c, input logic [3:0] v, input bit m);
    @(negedge clk);
    rstn = ~hold_rst;
    ifa.en = e; ifa.clr = c; ifa.cnt_in = v; ifa.mode = m;
    ifb.en = e; ifb.clr = c; ifb.cnt_in = v; ifb.mode = m;
    model_step(e, c, int'(v), m);
    q.push_back(cur);
  endtask

  task automatic sample(input logic [3:0] v, input bit m);
    drive(1'b1, 1'b0, v, m);
  endtask

  // Asynchronous reset asserted in the low phase, checked before any clock edge.
  task automatic async_reset(input int cycles);
    exp_t z;
    @(negedge clk);
    ifa.en = 1'b1; ifb.en = 1'b1;
    #2;
    rstn = 1'b0;
    hold_rst = 1'b1;
    model_reset();
    model_fill();
    z = cur;
    q.push_back(z);
    #1;
    check_both("async_rst", z);
    repeat (cycles) drive(1'b1, 1'b0, 4'd3, 1'b1);
    hold_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cnt;
    bit e, c, m;
    exp_t z;

    rstn = 1'b1;
    ifa.en = 0; ifa.clr = 0; ifa.cnt_in = '0; ifa.mode = 0;
    ifb.en = 0; ifb.clr = 0; ifb.cnt_in = '0; ifb.mode = 0;
    model_reset();
    #1 rstn = 1'b0;
    hold_rst = 1'b1;
    model_fill();
    z = cur;
    #1 check_both("reset", z);
    repeat (2) drive(1'b0, 1'b0, 4'd0, 1'b0);
    hold_rst = 1'b0;

    // Up wrap
    for (int i = 0; i < 16; i++) sample(4'(i), 1'b1);
    sample(4'd0, 1'b1);
    sample(4'd1, 1'b1);

    // Down wrap
    drive(1'b0, 1'b1, 4'd0, 1'b0);
    sample(4'd2, 1'b0); sample(4'd1, 1'b0); sample(4'd0, 1'b0);
    sample(4'd15, 1'b0); sample(4'd14, 1'b0);

    // Direction reversal
    drive(1'b0, 1'b1, 4'd0, 1'b0);
    sample(4'd5, 1'b1); sample(4'd6, 1'b0); sample(4'd5, 1'b0);
    sample(4'd4, 1'b1); sample(4'd5, 1'b1);

    // Illegal step then a would-be wrap while faulted
    drive(1'b0, 1'b1, 4'd0, 1'b0);
    sample(4'd3, 1'b1); sample(4'd4, 1'b1); sample(4'd6, 1'b1);
    sample(4'd15, 1'b1); sample(4'd0, 1'b1); sample(4'd1, 1'b1);

    // clr with a concurrent sample, en gating, first sample unchecked
    drive(1'b1, 1'b1, 4'd9, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 4'd2, 1'b1);
    sample(4'd7, 1'b1); sample(4'd8, 1'b1); sample(4'd9, 1'b1);

    // Saturation: alternating up/down wraps, five in total
    drive(1'b0, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample(4'd15, 1'b1);
      sample(4'd0, 1'b0);
    end

    // Async reset mid-operation; first sample after release is unchecked
    async_reset(2);
    sample(4'd7, 1'b0); sample(4'd6, 1'b0); sample(4'd5, 1'b0);

    // Randomized: a modelled up/down counter with occasional glitches, clr and gaps
    cnt = 4'($urandom_range(0, 15));
    m = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 4) == 0) m = ~m;
      if (n == 1500) async_reset(1);
      drive(e, c, cnt, m);
      if (e && !c) begin
        cnt = m ? cnt + 4'd1 : cnt - 4'd1;
        if ($urandom_range(0, 39) == 0) cnt = cnt + 4'($urandom_range(1, 15));
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
